// File: rtl/cache_cam_pkg.sv
// rtl/cache_cam_pkg.sv - shared types and defaults for the cache page-table CAM
// Purpose: command/status encodings, FSM states and default field widths.
// Ports: none (package).
package cache_cam_pkg;

  localparam int PS_WIDTH  = 5;
  localparam int KEY_WIDTH = 14;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_STORE  = 3'd1,
    CMD_VALID  = 3'd2,
    CMD_DIRTY  = 3'd3,
    CMD_DONE   = 3'd4,
    CMD_CHG_PS = 3'd5,
    CMD_ERASE  = 3'd6,
    CMD_FLUSH  = 3'd7
  } cache_cam_cmd_e;

  typedef enum logic [1:0] {
    PAGE_FREE     = 2'd0,
    PAGE_RESERVED = 2'd1,
    PAGE_VALID    = 2'd2,
    PAGE_DIRTY    = 2'd3
  } cache_page_status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cache_cam_seg_match.sv
// rtl/cache_cam_seg_match.sv - one search segment: lowest-index hit and free lane
// Purpose: compares LANES entries against a key, priority-encodes to lowest lane.
// Ports:
//   i_status   LANES x 2-bit entry status, lane 0 in the low bits
//   i_keys     LANES x KEY_WIDTH entry keys, lane 0 in the low bits
//   i_key      key being searched
//   o_any_hit  some non-FREE lane holds i_key
//   o_hit_ofs  lowest hitting lane
//   o_any_free some lane is FREE
//   o_free_ofs lowest FREE lane
module cache_cam_seg_match #(
  parameter int LANES     = 4,
  parameter int KEY_WIDTH = 14,
  parameter int OFS_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*2-1:0]         i_status,
  input  logic [LANES*KEY_WIDTH-1:0] i_keys,
  input  logic [KEY_WIDTH-1:0]       i_key,
  output logic                       o_any_hit,
  output logic [OFS_W-1:0]           o_hit_ofs,
  output logic                       o_any_free,
  output logic [OFS_W-1:0]           o_free_ofs
);
  import cache_cam_pkg::*;

  // Walk from the top lane down so the lowest matching lane is written last.
  always_comb begin
    o_any_hit  = 1'b0;
    o_hit_ofs  = '0;
    o_any_free = 1'b0;
    o_free_ofs = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (i_status[i*2 +: 2] != PAGE_FREE) begin
        if (i_keys[i*KEY_WIDTH +: KEY_WIDTH] == i_key) begin
          o_any_hit = 1'b1;
          o_hit_ofs = OFS_W'(i);
        end
      end else begin
        o_any_free = 1'b1;
        o_free_ofs = OFS_W'(i);
      end
    end
  end

endmodule

// File: rtl/cache_cam_array.sv
// rtl/cache_cam_array.sv - parametrised register-based CAM page table
// Purpose: DEPTH entries of {status, ps_id, key}; one command at a time,
//   searched LANES entries per cycle, single-cycle response pulse.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/key/ps_id      command opcode, lookup key, ps_id for STORE/CHG_PS
//   rsp_valid             one-cycle response pulse
//   rsp_hit/err/idx       hit flag, error flag, hit or allocated index
//   rsp_status/ps_id      entry contents before the update
//   free_cnt              number of FREE entries
module cache_cam_array #(
  parameter int DEPTH     = 128,
  parameter int KEY_WIDTH = cache_cam_pkg::KEY_WIDTH,
  parameter int PS_WIDTH  = cache_cam_pkg::PS_WIDTH,
  parameter int LANES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [KEY_WIDTH-1:0]       cmd_key,
  input  logic [PS_WIDTH-1:0]        cmd_ps_id,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH)-1:0]   rsp_idx,
  output logic [1:0]                 rsp_status,
  output logic [PS_WIDTH-1:0]        rsp_ps_id,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt
);
  import cache_cam_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NSEG  = DEPTH / LANES;
  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int OFS_W = (LANES > 1) ? $clog2(LANES) : 1;

  cache_page_status_e   r_status [DEPTH];
  logic [PS_WIDTH-1:0]  r_ps     [DEPTH];
  logic [KEY_WIDTH-1:0] r_key    [DEPTH];

  cam_state_e           r_state;
  cache_cam_cmd_e       r_op;
  logic [KEY_WIDTH-1:0] r_cmd_key;
  logic [PS_WIDTH-1:0]  r_cmd_ps;
  logic [SEG_W-1:0]     r_seg;
  logic                 r_free_found;
  logic [IDX_W-1:0]     r_free_idx;
  logic [CNT_W-1:0]     r_free_cnt;

  logic                 r_rsp_valid;
  logic                 r_rsp_hit;
  logic                 r_rsp_err;
  logic [IDX_W-1:0]     r_rsp_idx;
  cache_page_status_e   r_rsp_status;
  logic [PS_WIDTH-1:0]  r_rsp_ps;

  logic [IDX_W-1:0]           w_base;
  logic [LANES*2-1:0]         w_seg_status;
  logic [LANES*KEY_WIDTH-1:0] w_seg_key;
  logic                       w_any_hit;
  logic [OFS_W-1:0]           w_hit_ofs;
  logic                       w_any_free;
  logic [OFS_W-1:0]           w_free_ofs;
  logic [IDX_W-1:0]           w_hit_idx;
  logic [IDX_W-1:0]           w_seg_free_idx;
  logic                       w_free_any;
  logic [IDX_W-1:0]           w_free_idx;
  logic                       w_last;
  cache_page_status_e         w_hit_status;
  logic [PS_WIDTH-1:0]        w_hit_ps;
  logic                       w_err;
  logic [IDX_W-1:0]           w_idx;

  // Gather the current segment's entries for the comparator.
  always_comb begin
    w_base       = IDX_W'(r_seg) * IDX_W'(LANES);
    w_seg_status = '0;
    w_seg_key    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_seg_status[i*2 +: 2]                = r_status[w_base + IDX_W'(i)];
      w_seg_key[i*KEY_WIDTH +: KEY_WIDTH]   = r_key[w_base + IDX_W'(i)];
    end
  end

  cache_cam_seg_match #(
    .LANES     (LANES),
    .KEY_WIDTH (KEY_WIDTH),
    .OFS_W     (OFS_W)
  ) u_seg_match (
    .i_status   (w_seg_status),
    .i_keys     (w_seg_key),
    .i_key      (r_cmd_key),
    .o_any_hit  (w_any_hit),
    .o_hit_ofs  (w_hit_ofs),
    .o_any_free (w_any_free),
    .o_free_ofs (w_free_ofs)
  );

  assign w_hit_idx      = w_base + IDX_W'(w_hit_ofs);
  assign w_seg_free_idx = w_base + IDX_W'(w_free_ofs);
  // A free slot found in an earlier segment always has the lower index.
  assign w_free_any     = r_free_found | w_any_free;
  assign w_free_idx     = r_free_found ? r_free_idx : w_seg_free_idx;
  assign w_last         = (r_seg == SEG_W'(NSEG - 1));

  // Response contents, valid in the SEARCH cycle that ends the search.
  always_comb begin
    w_hit_status = r_status[w_hit_idx];
    w_hit_ps     = r_ps[w_hit_idx];
    w_err        = 1'b0;
    case (r_op)
      CMD_STORE: w_err = !w_any_hit && !w_free_any;
      CMD_VALID: w_err = w_any_hit && (w_hit_status != PAGE_RESERVED);
      CMD_DIRTY: w_err = w_any_hit && (w_hit_status != PAGE_VALID) &&
                         (w_hit_status != PAGE_DIRTY);
      CMD_DONE:  w_err = w_any_hit && (w_hit_status != PAGE_DIRTY);
      default:   w_err = 1'b0;
    endcase
    if (w_any_hit) begin
      w_idx = w_hit_idx;
    end else if (r_op == CMD_STORE && w_free_any) begin
      w_idx = w_free_idx;
    end else begin
      w_idx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_status[i] <= PAGE_FREE;
        r_ps[i]     <= '0;
        r_key[i]    <= '0;
      end
      r_state      <= IDLE;
      r_op         <= CMD_NOP;
      r_cmd_key    <= '0;
      r_cmd_ps     <= '0;
      r_seg        <= '0;
      r_free_found <= 1'b0;
      r_free_idx   <= '0;
      r_free_cnt   <= CNT_W'(DEPTH);
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_idx    <= '0;
      r_rsp_status <= PAGE_FREE;
      r_rsp_ps     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op         <= cache_cam_cmd_e'(cmd_op);
            r_cmd_key    <= cmd_key;
            r_cmd_ps     <= cmd_ps_id;
            r_seg        <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
            if (cache_cam_cmd_e'(cmd_op) == CMD_FLUSH) begin
              // FLUSH needs no lookup; its response is all zeros.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          r_free_found <= w_free_any;
          r_free_idx   <= w_free_idx;
          if (w_any_hit || w_last) begin
            r_state      <= RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_hit    <= w_any_hit;
            r_rsp_err    <= w_err;
            r_rsp_idx    <= w_idx;
            r_rsp_status <= w_any_hit ? w_hit_status : PAGE_FREE;
            r_rsp_ps     <= w_any_hit ? w_hit_ps : '0;
          end else begin
            r_seg <= r_seg + 1'b1;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_rsp_valid  <= 1'b0;
          r_rsp_hit    <= 1'b0;
          r_rsp_err    <= 1'b0;
          r_rsp_idx    <= '0;
          r_rsp_status <= PAGE_FREE;
          r_rsp_ps     <= '0;
          case (r_op)
            CMD_STORE: begin
              if (!r_rsp_hit && !r_rsp_err) begin
                r_status[r_rsp_idx] <= PAGE_RESERVED;
                r_ps[r_rsp_idx]     <= r_cmd_ps;
                r_key[r_rsp_idx]    <= r_cmd_key;
                r_free_cnt          <= r_free_cnt - 1'b1;
              end
            end
            CMD_VALID: begin
              if (r_rsp_hit && !r_rsp_err) r_status[r_rsp_idx] <= PAGE_VALID;
            end
            CMD_DIRTY: begin
              if (r_rsp_hit && !r_rsp_err) r_status[r_rsp_idx] <= PAGE_DIRTY;
            end
            CMD_DONE: begin
              if (r_rsp_hit && !r_rsp_err) r_status[r_rsp_idx] <= PAGE_VALID;
            end
            CMD_CHG_PS: begin
              if (r_rsp_hit) r_ps[r_rsp_idx] <= r_cmd_ps;
            end
            CMD_ERASE: begin
              // Free entries are kept fully cleared so a later STORE reports zeros.
              if (r_rsp_hit) begin
                r_status[r_rsp_idx] <= PAGE_FREE;
                r_key[r_rsp_idx]    <= '0;
                r_ps[r_rsp_idx]     <= '0;
                r_free_cnt          <= r_free_cnt + 1'b1;
              end
            end
            CMD_FLUSH: begin
              for (int i = 0; i < DEPTH; i++) begin
                r_status[i] <= PAGE_FREE;
                r_ps[i]     <= '0;
                r_key[i]    <= '0;
              end
              r_free_cnt <= CNT_W'(DEPTH);
            end
            default: ;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_err    = r_rsp_err;
  assign rsp_idx    = r_rsp_idx;
  assign rsp_status = r_rsp_status;
  assign rsp_ps_id  = r_rsp_ps;
  assign free_cnt   = r_free_cnt;

endmodule
